// File: rtl/pwm_gpio_responder_if.sv
// pwm_gpio_responder_if
//   CPU PIO <-> PWM responder bundle for one channel.
//   ctrl_in      : [DUTY_W-1:0] duty, [DUTY_W] enable, [DUTY_W+1] polarity,
//                  [DUTY_W+2] request toggle, [DUTY_W+3] reserved
//   prescaler_in : tick prescaler value
//   status_out   : [DUTY_W-1:0] applied duty, [DUTY_W] running, [DUTY_W+1] applied polarity,
//                  [DUTY_W+2] ack toggle, [DUTY_W+3] update pending
//   pwm_out      : PWM waveform pin
//   master modport = CPU/fabric driver side, slave modport = responder side.
interface pwm_gpio_responder_if #(
   parameter int unsigned DUTY_W  = 10,
   parameter int unsigned PRESC_W = 32
);
   logic [DUTY_W+3:0]  ctrl_in;
   logic [PRESC_W-1:0] prescaler_in;
   logic [DUTY_W+3:0]  status_out;
   logic               pwm_out;

   modport master (
      output ctrl_in,
      output prescaler_in,
      input  status_out,
      input  pwm_out
   );

   modport slave (
      input  ctrl_in,
      input  prescaler_in,
      output status_out,
      output pwm_out
   );
endinterface

// File: rtl/pwm_gpio_responder.sv
// pwm_gpio_responder
//   Fabric-side responder for one PWM channel. Shadows the CPU control word and prescaler,
//   applies updates via a toggle req/ack handshake at PWM period boundaries (or immediately
//   while idle), and generates a registered PWM waveform.
// Ports:
//   clk          : system clock
//   reset        : synchronous, active-high reset
//   bus (slave)  : ctrl_in / prescaler_in from the CPU PIOs, status_out / pwm_out back
//   period_irq   : one-cycle pulse after each period wrap while running
//                  (present only when PWM_PERIOD_IRQ_EN is defined)
// Optional feature macro: PWM_PERIOD_IRQ_EN
module pwm_gpio_responder #(
   parameter int unsigned DUTY_W  = 10,
   parameter int unsigned PRESC_W = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   pwm_gpio_responder_if.slave   bus
`ifdef PWM_PERIOD_IRQ_EN
   ,
   output logic                  period_irq
`endif
);

   localparam int unsigned        CtrlW  = DUTY_W + 4;
   localparam logic [DUTY_W-1:0]  CntMax = '1;

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e              state_q, state_d;
   logic [DUTY_W-1:0]   duty_q, duty_d;
   logic                pol_q, pol_d;
   logic [PRESC_W-1:0]  presc_q, presc_d;
   logic [PRESC_W-1:0]  pcnt_q, pcnt_d;
   logic [DUTY_W-1:0]   cnt_q, cnt_d;
   logic                ack_q, ack_d;
   logic                pwm_q, pwm_d;
   logic [CtrlW-1:0]    status_q, status_d;

   logic en, req, pending, running, tick, wrap, load;

   assign en      = bus.ctrl_in[DUTY_W];
   assign req     = bus.ctrl_in[DUTY_W+2];
   assign pending = req ^ ack_q;
   assign running = (state_q == StRun);
   // A cycle that sees enable drop does not advance the counters.
   assign tick    = running && en && (pcnt_q == presc_q);
   assign wrap    = tick && (cnt_q == CntMax);

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      pol_d   = pol_q;
      presc_d = presc_q;
      ack_d   = ack_q;
      pcnt_d  = pcnt_q;
      cnt_d   = cnt_q;
      load    = 1'b0;

      unique case (state_q)
         StIdle: begin
            pcnt_d = '0;
            cnt_d  = '0;
            // Enable wins over the handshake; the enable load also acks.
            if (en) begin
               state_d = StRun;
               load    = 1'b1;
            end else if (pending) begin
               load = 1'b1;
            end
         end
         StRun: begin
            if (!en) begin
               state_d = StIdle;
               pcnt_d  = '0;
               cnt_d   = '0;
            end else begin
               if (tick) begin
                  pcnt_d = '0;
                  cnt_d  = cnt_q + DUTY_W'(1);
               end else begin
                  pcnt_d = pcnt_q + PRESC_W'(1);
               end
               // Apply on the wrap so the new settings start cleanly at cnt=0.
               if (wrap && pending) begin
                  load = 1'b1;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         duty_d  = bus.ctrl_in[DUTY_W-1:0];
         pol_d   = bus.ctrl_in[DUTY_W+1];
         presc_d = bus.prescaler_in;
         ack_d   = req;
      end

      // Drop to the idle level in the same edge that sees enable fall.
      pwm_d    = (running && en) ? ((cnt_q < duty_q) ^ pol_q) : pol_q;
      status_d = {pending, ack_q, pol_q, running, duty_q};
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         duty_q   <= '0;
         pol_q    <= 1'b0;
         presc_q  <= '0;
         pcnt_q   <= '0;
         cnt_q    <= '0;
         ack_q    <= 1'b0;
         pwm_q    <= 1'b0;
         status_q <= '0;
      end else begin
         state_q  <= state_d;
         duty_q   <= duty_d;
         pol_q    <= pol_d;
         presc_q  <= presc_d;
         pcnt_q   <= pcnt_d;
         cnt_q    <= cnt_d;
         ack_q    <= ack_d;
         pwm_q    <= pwm_d;
         status_q <= status_d;
      end
   end

   assign bus.pwm_out    = pwm_q;
   assign bus.status_out = status_q;

`ifdef PWM_PERIOD_IRQ_EN
   logic irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         irq_q <= 1'b0;
      end else begin
         irq_q <= wrap;
      end
   end

   assign period_irq = irq_q;
`endif

endmodule

// File: tb/tb_pwm_gpio_responder.sv
// Scoreboard bench for pwm_gpio_responder: the driver pushes per-cycle expectations
// (cycle stamp, output kind, value) and a negedge monitor pops and compares them.
module tb_pwm_gpio_responder;

   localparam int DW = 10;
   localparam int KPwm = 0;
   localparam int KSt  = 1;
   localparam int KIrq = 2;

   logic clk = 1'b0;
   logic reset;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;

   pwm_gpio_responder_if #(.DUTY_W(DW), .PRESC_W(32)) bus ();

`ifdef PWM_PERIOD_IRQ_EN
   logic period_irq;
`endif

   pwm_gpio_responder #(.DUTY_W(DW), .PRESC_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
`ifdef PWM_PERIOD_IRQ_EN
      ,
      .period_irq (period_irq)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          cyc;
      int          kind;
      logic [13:0] val;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t em;
   logic [13:0] act;

   // Monitor: compare every expectation stamped with the current cycle.
   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         em = sb.pop_front();
         n_tests++;
         if (em.cyc < cyc) begin
            n_fail++;
            $display("FAIL %s: expectation for cycle %0d not sampled (now %0d)",
                     em.name, em.cyc, cyc);
         end else begin
            act = 'x;
            case (em.kind)
               KPwm: act = {13'd0, bus.pwm_out};
               KSt:  act = bus.status_out;
`ifdef PWM_PERIOD_IRQ_EN
               KIrq: act = {13'd0, period_irq};
`endif
               default: act = 'x;
            endcase
            if (act !== em.val) begin
               n_fail++;
               $display("FAIL %s @cyc %0d: got %h, expected %h", em.name, cyc, act, em.val);
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic logic [13:0] mk_ctrl(int duty, bit en, bit pol, bit req);
      logic [9:0] d;
      d = duty[9:0];
      return {1'b0, req, pol, en, d};
   endfunction

   function automatic logic [13:0] mk_st(bit pend, bit ack, bit pol, bit run, int duty);
      logic [9:0] d;
      d = duty[9:0];
      return {pend, ack, pol, run, d};
   endfunction

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push(int kind, logic [13:0] v, string name);
      exp_t e;
      e.cyc  = cyc;
      e.kind = kind;
      e.val  = v;
      e.name = name;
      sb.push_back(e);
   endtask

   task automatic push_pwm(bit v, string name);
      push(KPwm, {13'd0, v}, name);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      bus.ctrl_in = '0;
      bus.prescaler_in = '0;
      next_cycle();
      next_cycle();
      reset = 1'b0;
   endtask

   // Enable from reset and check n cycles of waveform against the period model.
   task automatic run_pwm(int n, int duty, bit pol, int presc, string name);
      bit e;
      bus.ctrl_in = mk_ctrl(duty, 1'b1, pol, 1'b0);
      bus.prescaler_in = presc;
      for (int i = 1; i <= n; i++) begin
         next_cycle();
         if (i == 1) e = 1'b0;
         else        e = pol ^ ((((i - 2) / (presc + 1)) % 1024) < duty);
         push_pwm(e, name);
         if (i == 2) push(KSt, mk_st(0, 0, pol, 1, duty), {name, "_status"});
      end
   endtask

   initial begin
      bit e;

      // Reset with an all-ones control word, then leave the word on after release.
      reset = 1'b1;
      bus.ctrl_in = '1;
      bus.prescaler_in = '1;
      for (int i = 1; i <= 3; i++) begin
         next_cycle();
         push_pwm(1'b0, "reset_pwm");
         push(KSt, '0, "reset_status");
      end
      reset = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         next_cycle();
         push_pwm(1'b0, "post_reset_pwm");
         if (i == 1) push(KSt, mk_st(1, 0, 0, 0, 0), "post_reset_pending");
         else        push(KSt, mk_st(0, 1, 1, 1, 1023), "post_reset_run");
      end

      // Basic waveform: presc=1, duty=256 -> 512 high / 1536 low per 2048 cycles.
      do_reset();
      run_pwm(2060, 256, 1'b0, 1, "basic");

      // Duty boundaries at presc=0.
      do_reset();
      run_pwm(1030, 0, 1'b0, 0, "duty0");
      do_reset();
      run_pwm(1030, 1023, 1'b0, 0, "duty1023");
      do_reset();
      run_pwm(1030, 1023, 1'b1, 0, "duty1023_inv");
      do_reset();
      run_pwm(1030, 0, 1'b1, 0, "duty0_inv");

      // Mid-period update at cnt=50; must take effect exactly at the next cnt=0.
      do_reset();
      bus.ctrl_in = mk_ctrl(100, 1'b1, 1'b0, 1'b0);
      bus.prescaler_in = 0;
      for (int i = 1; i <= 2100; i++) begin
         next_cycle();
         if (i == 1) e = 1'b0;
         else        e = (((i - 2) % 1024) < ((i >= 1026) ? 900 : 100));
         push_pwm(e, "update_pwm");
         if (i == 52 || i == 1025) push(KSt, mk_st(1, 0, 0, 1, 100), "update_pending");
         if (i == 1026) push(KSt, mk_st(0, 1, 0, 1, 900), "update_applied");
         if (i == 51) bus.ctrl_in = mk_ctrl(900, 1'b1, 1'b0, 1'b1);
      end

      // Double toggle (no apply), disable at cnt=300, re-enable restart.
      do_reset();
      bus.ctrl_in = mk_ctrl(400, 1'b1, 1'b1, 1'b0);
      bus.prescaler_in = 0;
      for (int i = 1; i <= 2200; i++) begin
         next_cycle();
         if (i == 1)          e = 1'b0;
         else if (i <= 1325)  e = 1'b1 ^ (((i - 2) % 1024) < 400);
         else if (i <= 1336)  e = 1'b1;
         else                 e = 1'b1 ^ (((i - 1337) % 1024) < 700);
         push_pwm(e, "dtog_pwm");
         if (i == 12) push(KSt, mk_st(1, 0, 1, 1, 400), "dtog_pending");
         if (i == 13) push(KSt, mk_st(0, 0, 1, 1, 400), "dtog_no_apply");
         if (i == 1326) push(KSt, mk_st(0, 0, 1, 1, 400), "disable_edge");
         if (i == 1327) push(KSt, mk_st(0, 0, 1, 0, 400), "disabled");
         if (i == 1337) push(KSt, mk_st(0, 0, 1, 1, 700), "reenabled");
         if (i == 11)   bus.ctrl_in = mk_ctrl(700, 1'b1, 1'b1, 1'b1);
         if (i == 12)   bus.ctrl_in = mk_ctrl(700, 1'b1, 1'b1, 1'b0);
         if (i == 1325) bus.ctrl_in = mk_ctrl(700, 1'b0, 1'b1, 1'b0);
         if (i == 1335) bus.ctrl_in = mk_ctrl(700, 1'b1, 1'b1, 1'b0);
      end

`ifdef PWM_PERIOD_IRQ_EN
      // Period interrupt at presc=3: one pulse every 4096 cycles, none while idle.
      do_reset();
      for (int i = 1; i <= 20; i++) begin
         next_cycle();
         push(KIrq, 14'd0, "irq_idle");
      end
      bus.ctrl_in = mk_ctrl(512, 1'b1, 1'b0, 1'b0);
      bus.prescaler_in = 3;
      for (int i = 1; i <= 8300; i++) begin
         next_cycle();
         e = (i > 1) && (((i - 1) % 4096) == 0);
         push(KIrq, {13'd0, e}, "irq_run");
      end
      bus.ctrl_in = mk_ctrl(512, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 300; i++) begin
         next_cycle();
         push(KIrq, 14'd0, "irq_disabled");
      end
`endif

      next_cycle();
      next_cycle();
      @(negedge clk);
      #1;
      n_tests++;
      if (sb.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
